// File: rtl/rename_pkg.sv
// Shared types and pointer arithmetic for the rename free list.
// Pointers are {wrap, idx} over a non-power-of-two ring of FL_DEPTH entries.
package rename_pkg;

  localparam int unsigned P_ADDR_WIDTH = 7;
  localparam int unsigned L_ADDR_WIDTH = 5;
  localparam int unsigned P_REGS       = 2 ** P_ADDR_WIDTH;
  localparam int unsigned L_REGS       = 2 ** L_ADDR_WIDTH;
  localparam int unsigned FL_DEPTH     = P_REGS - L_REGS;
  localparam int unsigned FL_IW        = $clog2(FL_DEPTH);
  localparam int unsigned FL_CW        = $clog2(FL_DEPTH + 1);

  typedef logic [P_ADDR_WIDTH-1:0] preg_t;

  typedef struct packed {
    logic             wrap;
    logic [FL_IW-1:0] idx;
  } fl_ptr_t;

  // Advance a pointer by 0..2, folding idx at FL_DEPTH and toggling wrap.
  function automatic fl_ptr_t fl_ptr_add(input fl_ptr_t p, input logic [1:0] n);
    fl_ptr_t     r;
    int unsigned s;
    r = p;
    s = 32'(p.idx) + 32'(n);
    if (s >= FL_DEPTH) begin
      r.idx  = FL_IW'(s - FL_DEPTH);
      r.wrap = ~p.wrap;
    end else begin
      r.idx = FL_IW'(s);
    end
    return r;
  endfunction

  function automatic logic [FL_CW-1:0] fl_count(input fl_ptr_t head, input fl_ptr_t tail);
    if (head.wrap == tail.wrap) begin
      return FL_CW'(32'(tail.idx) - 32'(head.idx));
    end
    return FL_CW'(FL_DEPTH - 32'(head.idx) + 32'(tail.idx));
  endfunction

  // Pregs not claimed by the alias table at reset.
  function automatic preg_t fl_reset_entry(input int unsigned i);
    if (i < L_REGS / 2) begin
      return preg_t'(L_REGS / 2 + i);
    end
    return preg_t'(L_REGS + i);
  endfunction

endpackage

// File: rtl/free_list_ckp.sv
// Head-pointer snapshot store, one entry per branch checkpoint.
// Two write ports (port b wins on a collision) and one combinational read port.
module free_list_ckp
  import rename_pkg::*;
#(
  parameter int unsigned C_NUM = 2,
  parameter int unsigned IDW   = 1
) (
  input  logic           clk,
  input  logic           we_a,
  input  logic [IDW-1:0] waddr_a,
  input  fl_ptr_t        wdata_a,
  input  logic           we_b,
  input  logic [IDW-1:0] waddr_b,
  input  fl_ptr_t        wdata_b,
  input  logic [IDW-1:0] raddr,
  output fl_ptr_t        rdata
);

  fl_ptr_t ckp_q [C_NUM];

  always_ff @(posedge clk) begin
    if (we_a) ckp_q[waddr_a] <= wdata_a;
    if (we_b) ckp_q[waddr_b] <= wdata_b;
  end

  assign rdata = ckp_q[raddr];

endmodule

// File: rtl/free_list.sv
// Physical-register free list: dual allocate, dual reclaim, and head-pointer
// checkpoint/restore for branch misprediction recovery.
module free_list
  import rename_pkg::*;
#(
  parameter int unsigned C_NUM = 2,
  localparam int unsigned IDW  = (C_NUM > 1) ? $clog2(C_NUM) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pop_en_1,
  input  logic             pop_en_2,
  output preg_t            pop_data_1,
  output preg_t            pop_data_2,
  output logic             pop_valid_1,
  output logic             pop_valid_2,
  input  logic             push_en_1,
  input  logic             push_en_2,
  input  preg_t            push_data_1,
  input  preg_t            push_data_2,
  input  logic             take_checkpoint,
  input  logic             instr_num,
  input  logic             dual_branch,
  input  logic [IDW-1:0]   ckp_id,
  input  logic             restore,
  input  logic [IDW-1:0]   restore_id,
  output logic [FL_CW-1:0] free_count
);

  preg_t            mem_q [FL_DEPTH];
  fl_ptr_t          head_q, head_d, tail_q, tail_d, head_p1, tail_p1, push2_ptr;
  fl_ptr_t          snap_a, snap_b, ckp_rdata;
  logic [FL_CW-1:0] count_q;
  logic             pop_err, push_err, pop_1, pop_2, push_1, push_2, take;
  logic [1:0]       n_pop, n_push;
  logic [IDW-1:0]   ckp_next;

  always_comb begin
    head_p1     = fl_ptr_add(head_q, 2'd1);
    tail_p1     = fl_ptr_add(tail_q, 2'd1);
    pop_valid_1 = count_q >= FL_CW'(1);
    pop_valid_2 = count_q >= (pop_en_1 ? FL_CW'(2) : FL_CW'(1));
    pop_data_1  = mem_q[head_q.idx];
    pop_data_2  = pop_en_1 ? mem_q[head_p1.idx] : mem_q[head_q.idx];

    // A restore discards this cycle's pops, so an unbacked request is harmless then.
    pop_err = !restore && ((pop_en_1 && !pop_valid_1) || (pop_en_2 && !pop_valid_2));
    pop_1   = pop_en_1 && !pop_err && !restore;
    pop_2   = pop_en_2 && !pop_err && !restore;
    n_pop   = {1'b0, pop_1} + {1'b0, pop_2};

    n_push    = {1'b0, push_en_1} + {1'b0, push_en_2};
    push_err  = (32'(count_q) + 32'(n_push)) > FL_DEPTH;
    push_1    = push_en_1 && !push_err;
    push_2    = push_en_2 && !push_err;
    push2_ptr = push_1 ? tail_p1 : tail_q;

    snap_a   = fl_ptr_add(head_q, {1'b0, pop_1});
    snap_b   = fl_ptr_add(head_q, n_pop);
    take     = take_checkpoint && !restore;
    ckp_next = (ckp_id == IDW'(C_NUM - 1)) ? '0 : ckp_id + IDW'(1);

    head_d = restore ? ckp_rdata : fl_ptr_add(head_q, n_pop);
    tail_d = fl_ptr_add(tail_q, {1'b0, push_1} + {1'b0, push_2});
  end

  free_list_ckp #(
    .C_NUM (C_NUM),
    .IDW   (IDW)
  ) u_ckp (
    .clk     (clk),
    .we_a    (take),
    .waddr_a (ckp_id),
    .wdata_a ((dual_branch || !instr_num) ? snap_a : snap_b),
    .we_b    (take && dual_branch),
    .waddr_b (ckp_next),
    .wdata_b (snap_b),
    .raddr   (restore_id),
    .rdata   (ckp_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) mem_q[i] <= fl_reset_entry(i);
      head_q  <= '{wrap: 1'b0, idx: '0};
      tail_q  <= '{wrap: 1'b1, idx: '0};
      count_q <= FL_CW'(FL_DEPTH);
    end else begin
      assert (!pop_err);
      assert (!push_err);
      if (push_1) mem_q[tail_q.idx] <= push_data_1;
      if (push_2) mem_q[push2_ptr.idx] <= push_data_2;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= fl_count(head_d, tail_d);
    end
  end

  assign free_count = count_q;

endmodule

// File: tb/tb_free_list.sv
// Free-list bench: directed scenarios plus random traffic against a queue model
// where allocations are logged and a restore returns everything logged after the mark.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pop_en_1, pop_en_2, pop_valid_1, pop_valid_2;
  logic [6:0] pop_data_1, pop_data_2, push_data_1, push_data_2;
  logic       push_en_1, push_en_2;
  logic       take_checkpoint, instr_num, dual_branch, restore;
  logic [0:0] ckp_id, restore_id;
  logic [6:0] free_count;

  free_list dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pop_en_1        (pop_en_1),
    .pop_en_2        (pop_en_2),
    .pop_data_1      (pop_data_1),
    .pop_data_2      (pop_data_2),
    .pop_valid_1     (pop_valid_1),
    .pop_valid_2     (pop_valid_2),
    .push_en_1       (push_en_1),
    .push_en_2       (push_en_2),
    .push_data_1     (push_data_1),
    .push_data_2     (push_data_2),
    .take_checkpoint (take_checkpoint),
    .instr_num       (instr_num),
    .dual_branch     (dual_branch),
    .ckp_id          (ckp_id),
    .restore         (restore),
    .restore_id      (restore_id),
    .free_count      (free_count)
  );

  always #5 clk = ~clk;

  int fl[$];
  int log_q[$];
  int mark[2];
  bit mark_v[2];
  int rel_ptr;
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    fl.delete();
    for (int i = 0; i < 96; i++) fl.push_back(i < 16 ? 16 + i : 32 + i);
    log_q.delete();
    mark_v[0] = 1'b0;
    mark_v[1] = 1'b0;
    rel_ptr = 0;
  endtask

  task automatic idle();
    rst_n = 1'b1; pop_en_1 = 1'b0; pop_en_2 = 1'b0;
    push_en_1 = 1'b0; push_en_2 = 1'b0; push_data_1 = '0; push_data_2 = '0;
    take_checkpoint = 1'b0; instr_num = 1'b0; dual_branch = 1'b0; ckp_id = '0;
    restore = 1'b0; restore_id = '0;
  endtask

  // Check outputs against the model, clock once, then apply the cycle to the model.
  task automatic cycle();
    int need2, base, m, p1, p2;
    #1;
    need2 = pop_en_1 ? 2 : 1;
    chk("free_count", free_count, fl.size());
    chk("pop_valid_1", pop_valid_1, int'(fl.size() >= 1));
    chk("pop_valid_2", pop_valid_2, int'(fl.size() >= need2));
    if (fl.size() >= 1) chk("pop_data_1", pop_data_1, fl[0]);
    if (fl.size() >= need2) chk("pop_data_2", pop_data_2, fl[need2-1]);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (restore) begin
        m = mark[restore_id];
        while (log_q.size() > m) fl.push_front(log_q.pop_back());
        for (int id = 0; id < 2; id++) if (mark[id] > m) mark_v[id] = 1'b0;
      end else begin
        p1 = int'(pop_en_1);
        p2 = int'(pop_en_2);
        base = log_q.size();
        for (int k = 0; k < p1 + p2; k++) log_q.push_back(fl.pop_front());
        if (take_checkpoint) begin
          if (dual_branch) begin
            mark[ckp_id] = base + p1;
            mark[ckp_id ^ 1'b1] = base + p1 + p2;
            mark_v[0] = 1'b1;
            mark_v[1] = 1'b1;
          end else begin
            mark[ckp_id] = base + p1 + (instr_num ? p2 : 0);
            mark_v[ckp_id] = 1'b1;
          end
        end
      end
      if (push_en_1) fl.push_back(int'(push_data_1));
      if (push_en_2) fl.push_back(int'(push_data_2));
    end
    @(negedge clk);
  endtask

  initial begin
    int lim, k, e0, e1;
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Reset view and dual allocation.
    pop_en_1 = 1'b1; pop_en_2 = 1'b1;
    #1;
    chk("rst_valid_1", pop_valid_1, 1);
    chk("rst_valid_2", pop_valid_2, 1);
    chk("rst_data_1", pop_data_1, 16);
    chk("rst_data_2", pop_data_2, 17);
    chk("rst_count", free_count, 96);
    repeat (8) cycle();
    #1;
    chk("pop8_count", free_count, 80);
    chk("pop8_data_1", pop_data_1, 48);
    chk("pop8_data_2", pop_data_2, 49);
    repeat (40) cycle();

    // Empty list, then push into it.
    idle();
    #1;
    chk("empty_count", free_count, 0);
    chk("empty_valid_1", pop_valid_1, 0);
    push_en_1 = 1'b1; push_en_2 = 1'b1; push_data_1 = 7'd5; push_data_2 = 7'd9;
    cycle();
    idle();
    pop_en_1 = 1'b1;
    #1;
    chk("refill_valid_2", pop_valid_2, 1);
    chk("refill_data_1", pop_data_1, 5);
    chk("refill_data_2", pop_data_2, 9);
    chk("refill_count", free_count, 2);

    // Reset in mid-operation.
    idle();
    rst_n = 1'b0;
    cycle();
    idle();
    #1;
    chk("midrst_count", free_count, 96);
    chk("midrst_data_1", pop_data_1, 16);

    // Dual checkpoint at reset head, then roll back to the slot-1 branch.
    take_checkpoint = 1'b1; dual_branch = 1'b1; ckp_id = 1'b1;
    pop_en_1 = 1'b1; pop_en_2 = 1'b1;
    cycle();
    take_checkpoint = 1'b0; dual_branch = 1'b0;
    repeat (3) cycle();
    idle();
    restore = 1'b1; restore_id = 1'b1;
    cycle();
    idle();
    #1;
    chk("restore_data_1", pop_data_1, 17);
    chk("restore_count", free_count, 95);

    // Restore alongside a push and an ignored pop request.
    take_checkpoint = 1'b1; instr_num = 1'b1; ckp_id = 1'b0;
    pop_en_1 = 1'b1; pop_en_2 = 1'b1;
    cycle();
    take_checkpoint = 1'b0; instr_num = 1'b0;
    cycle();
    restore = 1'b1; restore_id = 1'b0;
    push_en_1 = 1'b1; push_data_1 = 7'd3;
    cycle();
    idle();
    #1;
    chk("rst_push_count", free_count, 94);
    chk("rst_push_data_1", pop_data_1, 19);
    pop_en_1 = 1'b1; pop_en_2 = 1'b1;
    repeat (46) cycle();
    #1;
    chk("tail_append", pop_data_2, 3);
    cycle();

    // Wrap-around: drain everything, then refill across the ring end.
    idle();
    rst_n = 1'b0;
    cycle();
    idle();
    pop_en_1 = 1'b1; pop_en_2 = 1'b1;
    repeat (48) cycle();
    idle();
    for (int j = 0; j < 48; j++) begin
      e0 = 2 * j;
      e1 = 2 * j + 1;
      push_en_1 = 1'b1; push_en_2 = 1'b1;
      push_data_1 = 7'(e0 < 16 ? 16 + e0 : 32 + e0);
      push_data_2 = 7'(e1 < 16 ? 16 + e1 : 32 + e1);
      if (j == 47) chk("wrap_before", dut.tail_q.wrap, 1);
      cycle();
    end
    idle();
    #1;
    chk("wrap_after", dut.tail_q.wrap, 0);
    chk("full_count", free_count, 96);
    chk("full_valid_1", pop_valid_1, 1);
    chk("full_data_1", pop_data_1, 16);

    // Random traffic with commit-ordered releases below every live checkpoint.
    rst_n = 1'b0;
    cycle();
    for (int i = 0; i < 1500; i++) begin
      idle();
      k = 0;
      if (i == 700) begin
        rst_n = 1'b0;
      end else begin
        pop_en_1 = (fl.size() >= 1) && ($urandom % 4 != 0);
        pop_en_2 = (fl.size() >= (pop_en_1 ? 2 : 1)) && ($urandom % 4 != 0);
        lim = log_q.size();
        for (int id = 0; id < 2; id++) if (mark_v[id] && mark[id] < lim) lim = mark[id];
        k = $urandom_range(0, (lim - rel_ptr) > 2 ? 2 : (lim - rel_ptr));
        if (k >= 1) push_data_1 = 7'(log_q[rel_ptr]);
        if (k == 2) push_data_2 = 7'(log_q[rel_ptr + 1]);
        if (k == 2) begin
          push_en_1 = 1'b1; push_en_2 = 1'b1;
        end else if (k == 1) begin
          if ($urandom % 2 == 0) push_en_1 = 1'b1;
          else begin
            push_en_2 = 1'b1;
            push_data_2 = push_data_1;
          end
        end
        take_checkpoint = ($urandom % 5 == 0);
        dual_branch = $urandom % 2;
        instr_num = $urandom % 2;
        ckp_id = 1'($urandom % 2);
        if ((mark_v[0] || mark_v[1]) && ($urandom % 10 == 0)) begin
          restore = 1'b1;
          restore_id = mark_v[0] && (!mark_v[1] || ($urandom % 2 == 0)) ? 1'b0 : 1'b1;
        end
      end
      cycle();
      if (i != 700) rel_ptr += k;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
